// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable 4-bit down-counter timing the memory access window.
module wait_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between instruction fetch and
// LDUR/STUR data accesses with a one-cycle acknowledge handshake.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DW          = 64
)
(
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [DW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [DW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait_cycles
    $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
  end

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic             owner;
  logic             last_grant;
  logic             we_q;
  logic             contended;
  logic             win_d;
  logic             grant;
  logic             done;
  logic             mem_we_n;
  logic [CNT_W-1:0] count;
  logic             cnt_zero;

  wait_counter u_wait_counter (
    .clock      (clock),
    .clear      (reset),
    .load       (grant),
    .enable     (state == ST_ACCESS),
    .load_value (LOAD_VAL),
    .count      (count),
    .zero       (cnt_zero)
  );

  // Next state, arbitration and the write strobe for the final access cycle.
  always_comb begin
    state_n   = state;
    contended = if_req & d_req;
    win_d     = contended ? (last_grant == OWN_IF) : d_req;
    grant     = (state == ST_IDLE) && (if_req || d_req);
    done      = (state == ST_ACCESS) && cnt_zero;
    mem_we_n  = (grant && (LOAD_VAL == '0) && win_d && d_we) ||
                ((state == ST_ACCESS) && (count == CNT_W'(1)) && we_q);
    case (state)
      ST_IDLE:   if (grant) state_n = ST_ACCESS;
      ST_ACCESS: if (cnt_zero) state_n = ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state  <= state_n;
      mem_en <= (state_n == ST_ACCESS);
      mem_we <= mem_we_n;
      busy   <= (state_n != ST_IDLE);
      if_ack <= done && (owner == OWN_IF);
      d_ack  <= done && (owner == OWN_D);
      if (grant) begin
        owner <= win_d ? OWN_D : OWN_IF;
        // Only contended grants move the fairness pointer.
        if (contended) last_grant <= win_d ? OWN_D : OWN_IF;
        if (win_d) begin
          we_q      <= d_we;
          mem_size  <= d_size;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          we_q      <= 1'b0;
          mem_size  <= SIZE_WORD;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (done) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
        end else begin
          d_rdata <= we_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported main memory between the LEGv8 control unit's instruction-fetch path and the LDUR/STUR data path. Each side raises a level request with a one-cycle acknowledge handshake. A three-state FSM grants one requester at a time, drives the memory for a fixed number of wait cycles, and returns registered read data. The block sits between the control unit and the RAM model. The control unit stalls its IF and EX0 states until the matching acknowledge pulse.

## Interface
- WAIT_CYCLES, 2, memory access cycles per transaction; legal range 1–15.
- DW, 64, data and address width.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; when low, all state and outputs are forced to their reset values.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  DW  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DW  fetched word; lower 32 bits hold the instruction.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  access size code (00 byte … 11 doubleword), passed through unchanged.
- d_addr, d_wdata  in  DW  data address and store data.
- d_ack  out  1  one-cycle pulse.
- d_rdata  out  DW  load data; 0 for stores.
- mem_en, mem_we  out  1  memory enable and write strobe.
- mem_size  out  2  size code to memory; 2'b10 for fetches.
- mem_addr, mem_wdata  out  DW  memory address and write data.
- mem_rdata  in  DW  memory read data; valid in the last access cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE → ACCESS:** taken when any request is high at the clock edge.
  - The winner's address, size, we and wdata are latched into internal registers.
  - The wait counter loads WAIT_CYCLES-1.
  - The owner bit is set to the winner.
- **Arbitration when one side requests:** that side is granted.
- **Arbitration when both request:** the side not granted last wins.
  - The last-grant register resets to IF, so the first contended grant goes to data.
- **ACCESS:**
  - mem_en = 1 and the latched fields drive mem_*.
  - mem_we is asserted only when the counter = 0 and the latched we = 1, so a store writes exactly once.
  - The counter decrements each cycle. At 0 the FSM moves to RESP and captures mem_rdata, or 0 for a store, into the owner's rdata register.
- **RESP:**
  - The owner's ack = 1 for exactly one cycle; the other ack stays 0.
  - The FSM returns to IDLE unconditionally.
- **Requester handshake obligations:**
  - A requester must deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
  - Fields of a pending request may change only before the grant edge; they are ignored after latching.
- A request arriving during ACCESS or RESP waits; it is not lost because req is level.
- d_rdata and if_rdata hold their last value until overwritten by the same owner's next completion.
- **Reset values:** all outputs 0, state IDLE, counter 0, last-grant register = IF.
- **Reset asserted mid-transaction:** the transaction is abandoned with no ack and no write, even if the reset lands in the final ACCESS cycle. Requesters must re-request.
- WAIT_CYCLES = 0 is illegal; a simulation-only check reports it.

## Timing
- Request sampled high at edge 0 → ACCESS for cycles 1..WAIT_CYCLES → ack high in cycle WAIT_CYCLES+1.
- With the default WAIT_CYCLES = 2, ack arrives in cycle 3.
- Minimum spacing between grants is WAIT_CYCLES+2 cycles, because RESP always passes through IDLE.
- If both sides are waiting, the loser is granted at the IDLE edge immediately after the winner's RESP.
- All outputs are registered or decoded from registered state only; there is no combinational path from req or addr to mem_*.

## Structure
- A shared include file defines:
  - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2;
  - OWN_IF = 1'b0 and OWN_D = 1'b1;
  - SIZE_WORD = 2'b10.
- One sub-module, `wait_counter`: 4-bit loadable down-counter with async active-low clear, load and enable inputs, and a zero flag output.
- The FSM, arbitration and output registers live in the top module.

## Test plan
- **Single fetch:** if_req with if_addr = 0x40 and mem_rdata = 0x8B020020 → if_ack in cycle 3, if_rdata = 0x8B020020, mem_size = 10, mem_we never asserted.
- **Single store:** d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_size = 11 → mem_we high only in cycle 2, d_ack in cycle 3, d_rdata = 0.
- **Contention:** if_req and d_req both rise at cycle 0 → data is acked at cycle 3, IF is granted at cycle 4 and acked at cycle 7. Repeating the contention → IF wins first.
- **Held request:** if_req left high after if_ack → a second fetch is acked 4 cycles later, and busy stays high except for one IDLE cycle.
- **Reset mid-access:** reset driven low in cycle 2 of a store → no mem_we pulse, no d_ack, all outputs 0, busy = 0. After reset is released with d_req still high, a fresh transaction completes normally.
- **WAIT_CYCLES = 1 and 15:** ack latency is 2 and 16 cycles respectively, and rdata is captured from the last ACCESS cycle.
